// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared opcodes, field positions, forward encodings and FSM states
package hazard_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    localparam int OP_HI = 31;
    localparam int OP_LO = 26;
    localparam int RS_HI = 25;
    localparam int RS_LO = 21;
    localparam int RT_HI = 20;
    localparam int RT_LO = 16;
    localparam int RD_HI = 15;
    localparam int RD_LO = 11;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_M  = 2'b01;
    localparam logic [1:0] FWD_W  = 2'b10;

    typedef enum logic {RUN, STALL} state_t;

    function automatic logic is_op(input logic [31:0] instr, input logic [5:0] op);
        return instr[OP_HI:OP_LO] == op;
    endfunction

endpackage

// File: rtl/hazard_ctrl_instr_regs.sv
// instr_regs: decode one instruction word into its source and destination registers
module instr_regs
    import hazard_ctrl_pkg::*;
(
    input  logic [31:0] instr,
    output logic [4:0]  src_a,
    output logic [4:0]  src_b,
    output logic [4:0]  dest,
    output logic        has_src_a,
    output logic        has_src_b,
    output logic        has_dest
);

    logic is_r, is_lw, is_two_src;
    logic unused_low;

    assign is_r       = is_op(instr, OP_RTYPE);
    assign is_lw      = is_op(instr, OP_LW);
    assign is_two_src = is_r | is_op(instr, OP_SW) | is_op(instr, OP_BEQ);
    assign src_a      = instr[RS_HI:RS_LO];
    assign src_b      = instr[RT_HI:RT_LO];
    assign has_src_a  = is_two_src | is_lw;
    assign has_src_b  = is_two_src;
    assign dest       = is_r ? instr[RD_HI:RD_LO] : is_lw ? instr[RT_HI:RT_LO] : 5'd0;
    // $0 is hardwired to zero, so writing it never produces a dependency
    assign has_dest   = (is_r | is_lw) & (dest != 5'd0);
    assign unused_low = ^instr[RD_LO-1:0];

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall, flush and forwarding control for the 5-stage pipeline
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instr_d,
    input  logic [31:0]      instr_e,
    input  logic [31:0]      instr_m,
    input  logic [31:0]      instr_w,
    input  logic             branch_taken_d,
    input  logic             mem_ready,
    output logic             stall_f,
    output logic             stall_d,
    output logic             stall_e,
    output logic             stall_m,
    output logic             flush_d,
    output logic             flush_e,
    output logic [1:0]       fwd_a_e,
    output logic [1:0]       fwd_b_e,
    output logic             fwd_a_d,
    output logic             fwd_b_d,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int D = 0;
    localparam int E = 1;
    localparam int M = 2;
    localparam int W = 3;

    logic [31:0] instr [4];
    logic [4:0]  src_a [4];
    logic [4:0]  src_b [4];
    logic [4:0]  dest [4];
    logic        has_src_a [4];
    logic        has_src_b [4];
    logic        has_dest [4];

    logic   beq_d, r_e, lw_e, r_m, lw_m, hit_e, hit_m, n1, n2, hold, mem_wait;
    state_t state, state_nx;
    logic [1:0] rem, rem_nx;

    assign instr[D] = instr_d;
    assign instr[E] = instr_e;
    assign instr[M] = instr_m;
    assign instr[W] = instr_w;

    for (genvar i = 0; i < 4; i++) begin : g_dec
        instr_regs u_dec (
            .instr     (instr[i]),
            .src_a     (src_a[i]),
            .src_b     (src_b[i]),
            .dest      (dest[i]),
            .has_src_a (has_src_a[i]),
            .has_src_b (has_src_b[i]),
            .has_dest  (has_dest[i])
        );
    end

    assign beq_d    = is_op(instr_d, OP_BEQ);
    assign r_e      = is_op(instr_e, OP_RTYPE);
    assign lw_e     = is_op(instr_e, OP_LW);
    assign r_m      = is_op(instr_m, OP_RTYPE);
    assign lw_m     = is_op(instr_m, OP_LW);
    assign mem_wait = (lw_m | is_op(instr_m, OP_SW)) & ~mem_ready;
    assign hit_e    = has_dest[E] & ((has_src_a[D] & (src_a[D] == dest[E])) |
                                     (has_src_b[D] & (src_b[D] == dest[E])));
    assign hit_m    = has_dest[M] & ((has_src_a[D] & (src_a[D] == dest[M])) |
                                     (has_src_b[D] & (src_b[D] == dest[M])));
    // a beq waiting on a load in E needs two bubbles; every other dependency needs one
    assign n2       = beq_d & lw_e & hit_e;
    assign n1       = (lw_e & hit_e) | (beq_d & r_e & hit_e) | (beq_d & lw_m & hit_m);
    assign hold     = (state == STALL) | n1 | n2;

    // state register and remaining-stall counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            rem   <= 2'd0;
        end else begin
            state <= state_nx;
            rem   <= rem_nx;
        end
    end

    // next state: memory wait freezes the sequencer, otherwise RUN enters STALL only for two-bubble hazards
    always_comb begin
        state_nx = state;
        rem_nx   = rem;
        if (!mem_wait && state == RUN && n2) begin
            state_nx = STALL;
            rem_nx   = 2'd1;
        end else if (!mem_wait && state == STALL) begin
            rem_nx   = rem - 2'd1;
            state_nx = (rem == 2'd1) ? RUN : STALL;
        end
    end

    // stall and flush enables, forced low while reset is held
    always_comb begin
        stall_f = rst_n & (mem_wait | hold);
        stall_d = rst_n & (mem_wait | hold);
        stall_e = rst_n & mem_wait;
        stall_m = rst_n & mem_wait;
        flush_e = rst_n & ~mem_wait & hold;
        flush_d = rst_n & branch_taken_d & ~mem_wait & ~hold;
    end

    // forwarding selects, M result takes priority over W writeback
    always_comb begin
        fwd_a_e = (r_m & has_dest[M] & has_src_a[E] & (dest[M] == src_a[E])) ? FWD_M :
                  (has_dest[W] & has_src_a[E] & (dest[W] == src_a[E])) ? FWD_W : FWD_RF;
        fwd_b_e = (r_m & has_dest[M] & has_src_b[E] & (dest[M] == src_b[E])) ? FWD_M :
                  (has_dest[W] & has_src_b[E] & (dest[W] == src_b[E])) ? FWD_W : FWD_RF;
        fwd_a_d = beq_d & r_m & has_dest[M] & has_src_a[D] & (dest[M] == src_a[D]);
        fwd_b_d = beq_d & r_m & has_dest[M] & has_src_b[D] & (dest[M] == src_b[D]);
    end

    // saturating count of fetch-stall cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (stall_f && !(&stall_cnt))
            stall_cnt <= stall_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vectors with a scoreboard queue checked by a negedge monitor
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr_d = '0, instr_e = '0, instr_m = '0, instr_w = '0;
    logic        branch_taken_d = 1'b0;
    logic        mem_ready = 1'b1;
    logic        stall_f, stall_d, stall_e, stall_m, flush_d, flush_e;
    logic [1:0]  fwd_a_e, fwd_b_e;
    logic        fwd_a_d, fwd_b_d;
    logic [15:0] stall_cnt;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_cnt = '0;
    logic [27:0] exp_q [$];
    string       name_q [$];

    localparam logic [31:0] NOP    = 32'h0000_0000;
    localparam logic [31:0] LW2    = 32'h8C22_0000;
    localparam logic [31:0] ADD3   = 32'h0044_1820;
    localparam logic [31:0] BEQ2   = 32'h1040_0003;
    localparam logic [31:0] BEQ3   = 32'h1060_0003;
    localparam logic [31:0] SW     = 32'hAC22_0000;
    localparam logic [31:0] ADD0   = 32'h0022_0020;
    localparam logic [31:0] ADD4   = 32'h0000_2020;
    localparam logic [31:0] ADDR3  = 32'h0022_1820;
    localparam logic [31:0] LW3    = 32'h8C23_0000;
    localparam logic [31:0] ADD533 = 32'h0063_2820;

    hazard_ctrl #(.CNT_W(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .instr_d        (instr_d),
        .instr_e        (instr_e),
        .instr_m        (instr_m),
        .instr_w        (instr_w),
        .branch_taken_d (branch_taken_d),
        .mem_ready      (mem_ready),
        .stall_f        (stall_f),
        .stall_d        (stall_d),
        .stall_e        (stall_e),
        .stall_m        (stall_m),
        .flush_d        (flush_d),
        .flush_e        (flush_e),
        .fwd_a_e        (fwd_a_e),
        .fwd_b_e        (fwd_b_e),
        .fwd_a_d        (fwd_a_d),
        .fwd_b_d        (fwd_b_d),
        .stall_cnt      (stall_cnt)
    );

    always #5 clk = ~clk;

    // st = {stall_f,stall_d,stall_e,stall_m}, fl = {flush_d,flush_e}, fdd = {fwd_a_d,fwd_b_d}
    task automatic step(input string nm, input logic rn,
                        input logic [31:0] d, input logic [31:0] e, input logic [31:0] m, input logic [31:0] w,
                        input logic bt, input logic mr, input logic [3:0] st, input logic [1:0] fl,
                        input logic [1:0] fa, input logic [1:0] fb, input logic [1:0] fdd);
        @(posedge clk);
        #1;
        rst_n = rn;
        instr_d = d;
        instr_e = e;
        instr_m = m;
        instr_w = w;
        branch_taken_d = bt;
        mem_ready = mr;
        if (!rn) exp_cnt = '0;
        exp_q.push_back({st, fl, fa, fb, fdd, exp_cnt});
        name_q.push_back(nm);
        if (st[3]) exp_cnt = exp_cnt + 16'd1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [27:0] exp_v, act_v;
            string       nm;
            exp_v = exp_q.pop_front();
            nm    = name_q.pop_front();
            act_v = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e,
                     fwd_a_e, fwd_b_e, fwd_a_d, fwd_b_d, stall_cnt};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL %s: got st=%b fl=%b fa=%b fb=%b fd=%b cnt=%0d, expected st=%b fl=%b fa=%b fb=%b fd=%b cnt=%0d",
                         nm, act_v[27:24], act_v[23:22], act_v[21:20], act_v[19:18], act_v[17:16], act_v[15:0],
                         exp_v[27:24], exp_v[23:22], exp_v[21:20], exp_v[19:18], exp_v[17:16], exp_v[15:0]);
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        step("reset_gates_outputs", 0, ADD3, LW2,  NOP, NOP, 1, 1, 4'b0000, 2'b00, 2'b00, 2'b00, 2'b00);
        step("load_use_stall",      1, ADD3, LW2,  NOP, NOP, 0, 1, 4'b1100, 2'b01, 2'b00, 2'b00, 2'b00);
        step("load_use_fwd_w",      1, NOP,  ADD3, NOP, LW2, 0, 1, 4'b0000, 2'b00, 2'b10, 2'b00, 2'b00);
        step("beq_lw_e_run",        1, BEQ2, LW2,  NOP, NOP, 1, 1, 4'b1100, 2'b01, 2'b00, 2'b00, 2'b00);
        step("beq_lw_e_stall",      1, BEQ2, NOP,  LW2, NOP, 1, 1, 4'b1100, 2'b01, 2'b00, 2'b00, 2'b00);
        step("beq_resolved_flush",  1, BEQ2, NOP,  NOP, LW2, 1, 1, 4'b0000, 2'b10, 2'b00, 2'b00, 2'b00);
        step("memwait_1",           1, NOP,  NOP,  SW,  NOP, 1, 0, 4'b1111, 2'b00, 2'b00, 2'b00, 2'b00);
        step("memwait_2",           1, NOP,  NOP,  SW,  NOP, 0, 0, 4'b1111, 2'b00, 2'b00, 2'b00, 2'b00);
        step("memwait_3",           1, NOP,  NOP,  SW,  NOP, 0, 0, 4'b1111, 2'b00, 2'b00, 2'b00, 2'b00);
        step("memwait_done",        1, NOP,  NOP,  SW,  NOP, 0, 1, 4'b0000, 2'b00, 2'b00, 2'b00, 2'b00);
        step("stall_enter",         1, BEQ2, LW2,  NOP, NOP, 0, 1, 4'b1100, 2'b01, 2'b00, 2'b00, 2'b00);
        step("stall_memwait_1",     1, BEQ2, NOP,  SW,  NOP, 0, 0, 4'b1111, 2'b00, 2'b00, 2'b00, 2'b00);
        step("stall_memwait_2",     1, BEQ2, NOP,  SW,  NOP, 0, 0, 4'b1111, 2'b00, 2'b00, 2'b00, 2'b00);
        step("stall_rem_held",      1, BEQ2, NOP,  SW,  NOP, 0, 1, 4'b1100, 2'b01, 2'b00, 2'b00, 2'b00);
        step("stall_exit_run",      1, BEQ2, NOP,  NOP, NOP, 0, 1, 4'b0000, 2'b00, 2'b00, 2'b00, 2'b00);
        step("zero_dest_no_fwd",    1, NOP,  ADD4, ADD0, NOP, 0, 1, 4'b0000, 2'b00, 2'b00, 2'b00, 2'b00);
        step("fwd_m_over_w",        1, NOP,  ADD533, ADDR3, LW3, 0, 1, 4'b0000, 2'b00, 2'b01, 2'b01, 2'b00);
        step("fwd_w_only",          1, NOP,  ADD533, NOP, LW3, 0, 1, 4'b0000, 2'b00, 2'b10, 2'b10, 2'b00);
        step("fwd_d_from_m",        1, BEQ3, NOP,  ADDR3, NOP, 0, 1, 4'b0000, 2'b00, 2'b00, 2'b00, 2'b10);
        step("beq_r_e_stall",       1, BEQ3, ADDR3, NOP, NOP, 1, 1, 4'b1100, 2'b01, 2'b00, 2'b00, 2'b00);
        step("beq_fwd_flush",       1, BEQ3, NOP,  ADDR3, NOP, 1, 1, 4'b0000, 2'b10, 2'b00, 2'b00, 2'b10);
        step("beq_lw_m_stall",      1, BEQ3, NOP,  LW3, NOP, 1, 1, 4'b1100, 2'b01, 2'b00, 2'b00, 2'b00);
        step("after_lw_m",          1, NOP,  NOP,  NOP, NOP, 0, 1, 4'b0000, 2'b00, 2'b00, 2'b00, 2'b00);
        step("stall_before_reset",  1, BEQ2, LW2,  NOP, NOP, 0, 1, 4'b1100, 2'b01, 2'b00, 2'b00, 2'b00);
        step("reset_in_stall",      0, BEQ2, LW2,  SW,  NOP, 1, 0, 4'b0000, 2'b00, 2'b00, 2'b00, 2'b00);
        step("post_reset_flush",    1, BEQ2, NOP,  NOP, NOP, 1, 1, 4'b0000, 2'b10, 2'b00, 2'b00, 2'b00);
        step("flush_one_cycle",     1, NOP,  NOP,  NOP, NOP, 0, 1, 4'b0000, 2'b00, 2'b00, 2'b00, 2'b00);
        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
